// File: rtl/array_ctrl_pkg.sv
// Shared definitions for the array controller: FSM state encoding and default geometry.
package array_ctrl_pkg;

    localparam int DEF_DEPTH = 1024;
    localparam int DEF_WIDTH = 12;
    localparam int DEF_AW    = 10;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/array_8_ctrl_resp_fifo2.sv
// Two-entry response FIFO with fall-through when empty, so a capture can be
// consumed in the same cycle it arrives.
module resp_fifo2 #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic w_stored;
    logic w_push;
    logic w_pop;
    logic w_store;
    logic w_deq;

    assign w_stored = (r_count != 2'd0);
    assign o_valid  = w_stored || i_valid;
    assign o_data   = w_stored ? r_mem[r_rptr] : i_data;
    assign o_ready  = (r_count != 2'd2) || i_ready;
    assign o_count  = r_count;

    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;
    // An arrival into an empty FIFO that is consumed immediately never lands in storage.
    assign w_store = w_push && !(!w_stored && i_ready);
    assign w_deq   = w_pop && w_stored;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_store) r_wptr <= ~r_wptr;
            if (w_deq)   r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/array_8_ctrl.sv
// Controller for a 1-cycle-latency dual-port SRAM: clears the array after reset,
// then serves read/write requests. Define ARRAY_CTRL_BYPASS_EN to forward write data on same-address collisions.
module array_8_ctrl
    import array_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [AW-1:0]    rd_addr,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             init_done,
    output logic [AW-1:0]    R0_addr,
    output logic             R0_en,
    input  logic [WIDTH-1:0] R0_data,
    output logic [AW-1:0]    W0_addr,
    output logic             W0_en,
    output logic [WIDTH-1:0] W0_data
);

    state_e           r_state;
    logic [AW-1:0]    r_cnt;
    logic             r_inflight;

    logic             w_run;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic             w_addr_hit;
    logic             w_pop;
    logic [1:0]       w_fifo_cnt;
    logic [1:0]       w_used;
    logic [1:0]       w_after_pop;
    logic             w_credit_ok;
    logic             w_fifo_in_ready;
    logic [WIDTH-1:0] w_cap_data;

    assign w_run      = (r_state == RUN);
    assign w_wr_fire  = wr_valid && w_run;
    assign w_addr_hit = w_wr_fire && (rd_addr == wr_addr);
    assign w_pop      = resp_valid && resp_ready;

    // One read can be in the SRAM pipeline; together with stored entries it may not exceed the FIFO depth.
    assign w_used      = {1'b0, r_inflight} + w_fifo_cnt;
    assign w_after_pop = w_used - {1'b0, w_pop};
    assign w_credit_ok = (w_after_pop < 2'd2);

`ifdef ARRAY_CTRL_BYPASS_EN
    assign rd_ready = w_run && w_credit_ok && w_fifo_in_ready;
`else
    assign rd_ready = w_run && w_credit_ok && w_fifo_in_ready && !w_addr_hit;
`endif

    assign w_rd_fire = rd_valid && rd_ready;
    assign wr_ready  = w_run;
    assign init_done = w_run;

    assign R0_en   = w_rd_fire;
    assign R0_addr = rd_addr;

    // The clear write is qualified by reset_n so nothing is written while reset is held.
    assign W0_en   = w_run ? w_wr_fire : reset_n;
    assign W0_addr = w_run ? wr_addr : r_cnt;
    assign W0_data = w_run ? wr_data : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= INIT;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == AW'(DEPTH - 1)) r_state <= RUN;
                end
                RUN: r_state <= RUN;
                default: r_state <= INIT;
            endcase
            r_inflight <= w_rd_fire;
        end
    end

`ifdef ARRAY_CTRL_BYPASS_EN
    logic             r_byp_sel;
    logic [WIDTH-1:0] r_byp_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_sel <= w_rd_fire && w_addr_hit;
            if (w_wr_fire) r_byp_data <= wr_data;
        end
    end

    assign w_cap_data = r_byp_sel ? r_byp_data : R0_data;
`else
    assign w_cap_data = R0_data;
`endif

    resp_fifo2 #(
        .WIDTH (WIDTH)
    ) u_resp_fifo (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_valid (r_inflight),
        .o_ready (w_fifo_in_ready),
        .i_data  (w_cap_data),
        .o_valid (resp_valid),
        .i_ready (resp_ready),
        .o_data  (resp_data),
        .o_count (w_fifo_cnt)
    );

endmodule

// File: tb/tb_array_8_ctrl.sv
// Self-checking bench for array_8_ctrl: behavioural SRAM, reference memory and
// response queue, directed scenarios plus randomized traffic.
module tb_array_8_ctrl;

    localparam int DEPTH = 1024;
    localparam int WIDTH = 12;
    localparam int AW    = 10;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             rd_valid = 1'b0;
    logic             rd_ready;
    logic [AW-1:0]    rd_addr = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [WIDTH-1:0] resp_data;
    logic             init_done;
    logic [AW-1:0]    R0_addr;
    logic             R0_en;
    logic [WIDTH-1:0] R0_data = '0;
    logic [AW-1:0]    W0_addr;
    logic             W0_en;
    logic [WIDTH-1:0] W0_data;

    array_8_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .init_done(init_done),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data)
    );

    always #5 clock = ~clock;

    // Behavioural 1-cycle-latency dual-port array.
    logic [WIDTH-1:0] sram [DEPTH];
    always @(posedge clock) begin
        if (W0_en) sram[W0_addr] <= W0_data;
        if (R0_en) R0_data <= sram[R0_addr];
    end

    // Reference model: array contents as software sees them and the responses still owed.
    logic [WIDTH-1:0] mem_m [DEPTH];
    logic [WIDTH-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit g_rd_fire;
    bit g_pop;
    int g_pop_cyc;
    logic [WIDTH-1:0] g_pop_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: inputs are already driven; sample handshakes, score, advance.
    task automatic cycle();
        bit wf;
        logic [WIDTH-1:0] ev;
        #1;
        wf        = wr_valid && wr_ready;
        g_rd_fire = rd_valid && rd_ready;
        g_pop     = resp_valid && resp_ready;
        if (init_done) chk("wr_ready_run", wr_ready, 1);
        if (exp_q.size() == 0) chk("resp_valid_idle", resp_valid, 0);
        if (g_pop && exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            chk("resp_data", resp_data, ev);
            g_pop_cyc  = cyc;
            g_pop_data = resp_data;
        end
`ifndef ARRAY_CTRL_BYPASS_EN
        if (wf && rd_addr == wr_addr) chk("collide_block", rd_ready, 0);
`endif
        if (g_rd_fire) exp_q.push_back((wf && rd_addr == wr_addr) ? wr_data : mem_m[rd_addr]);
        chk("outstanding_le2", exp_q.size() <= 2, 1);
        if (wf) mem_m[wr_addr] = wr_data;
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset_init();
        reset_n = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0; resp_ready = 1'b0;
        #1;
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_R0_en", R0_en, 0);
        chk("rst_W0_en", W0_en, 0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("init_W0_en", W0_en, 1);
            chk("init_W0_addr", W0_addr, i);
            chk("init_W0_data", W0_data, 0);
            chk("init_done_low", init_done, 0);
            chk("init_rd_ready", rd_ready, 0);
            @(posedge clock);
            @(negedge clock);
        end
        #1;
        chk("init_done_high", init_done, 1);
        chk("run_W0_idle", W0_en, 0);
    endtask

    task automatic write_one(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_valid = 1'b0;
    endtask

    // Issue one read (optionally with a same-cycle write), wait for its response.
    task automatic read_one(input logic [AW-1:0] a, input bit do_wr, input logic [WIDTH-1:0] wd,
                            output int lat, output logic [WIDTH-1:0] data);
        int  t0;
        bit  fired;
        bit  got;
        t0 = cyc; fired = 0; got = 0; lat = -1; data = '0;
        rd_valid = 1'b1; rd_addr = a;
        wr_valid = do_wr; wr_addr = a; wr_data = wd;
        resp_ready = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle();
            wr_valid = 1'b0;
            if (g_rd_fire) begin fired = 1; rd_valid = 1'b0; end
            else if (g_pop && fired) begin got = 1; lat = g_pop_cyc - t0; data = g_pop_data; end
        end
        rd_valid = 1'b0;
        chk("read_completed", got, 1);
    endtask

    initial begin
        int lat;
        int k;
        logic [WIDTH-1:0] d;

        // Reset mid-clear must stop clear writes immediately.
        #1;
        chk("por_W0_en", W0_en, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (50) @(negedge clock);
        #2;
        chk("midinit_W0_en_before", W0_en, 1);
        reset_n = 1'b0;
        #1;
        chk("midinit_W0_en", W0_en, 0);
        chk("midinit_init_done", init_done, 0);
        @(negedge clock);

        do_reset_init();

        read_one(10'd5, 0, '0, lat, d);
        chk("init_read5_data", d, 0);
        chk("init_read5_lat", lat, 1);

        write_one(10'd3, 12'hABC);
        read_one(10'd3, 0, '0, lat, d);
        chk("raw_data", d, 12'hABC);
        chk("raw_lat", lat, 1);

        read_one(10'd7, 1, 12'h123, lat, d);
        chk("collide_data", d, 12'h123);
`ifdef ARRAY_CTRL_BYPASS_EN
        chk("collide_lat", lat, 1);
`else
        chk("collide_lat", lat, 2);
`endif

        // Backpressure: only two reads may be outstanding.
        for (int i = 0; i < 4; i++) write_one(AW'(20 + i), WIDTH'($urandom));
        resp_ready = 1'b0; rd_valid = 1'b1; k = 0;
        for (int i = 0; i < 6; i++) begin
            rd_addr = AW'(20 + k);
            cycle();
            if (g_rd_fire) k++;
        end
        chk("bp_accepted", k, 2);
        #1;
        chk("bp_rd_ready", rd_ready, 0);
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && (k < 4 || exp_q.size() > 0); i++) begin
            rd_valid = (k < 4);
            rd_addr  = AW'(20 + k);
            cycle();
            if (g_rd_fire) k++;
        end
        rd_valid = 1'b0;
        chk("bp_all_accepted", k, 4);
        chk("bp_drained", exp_q.size(), 0);

        // Randomized traffic over a small address window to provoke collisions.
        for (int i = 0; i < 1500; i++) begin
            rd_valid   = ($urandom_range(0, 9) < 6);
            rd_addr    = AW'($urandom_range(0, 7));
            wr_valid   = ($urandom_range(0, 1) == 1);
            wr_addr    = AW'($urandom_range(0, 7));
            wr_data    = WIDTH'($urandom);
            resp_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        rd_valid = 1'b0; wr_valid = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle();
        chk("rand_drained", exp_q.size(), 0);

        // Reset with two responses buffered.
        resp_ready = 1'b0; rd_valid = 1'b1;
        rd_addr = 10'd1; cycle();
        rd_addr = 10'd2; cycle();
        rd_valid = 1'b0; cycle();
        #1;
        chk("buffered_resp_valid", resp_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_flush_resp_valid", resp_valid, 0);
        chk("rst_flush_init_done", init_done, 0);
        exp_q.delete();
        @(negedge clock);
        do_reset_init();

        read_one(10'd3, 0, '0, lat, d);
        chk("post_reset_cleared", d, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
